video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator for the VGA output path. It divides the system clock down to a pixel tick and runs horizontal/vertical pixel counters across a configurable display/porch/sync geometry. It produces sync pulses with selectable polarity, blanking flags, and line/frame start strobes, all aligned with the x/y coordinates. The pixel renderer and sprite logic consume x, y, video_on and p_tick directly; hsync/vsync go to the connector.

## Interface
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, in ticks
- H_SYNC, 96: hsync width, in ticks
- H_BACK, 48: horizontal back porch, in ticks
- V_DISPLAY, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BACK, 33: vertical back porch, in lines
- CLK_DIV, 4: clk cycles per pixel tick, ≥1
- H_SYNC_POL, 0: hsync active level (0 = active-low)
- V_SYNC_POL, 0: vsync active level
- CW, 10: x/y counter width
- FRAME_W, 8: frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  run enable; low freezes all state
- p_tick  out  1  pixel tick strobe, one clk wide
- x  out  CW  horizontal position
- y  out  CW  vertical position
- video_on  out  1  (x < H_DISPLAY) && (y < V_DISPLAY)
- hblank  out  1  x ≥ H_DISPLAY
- vblank  out  1  y ≥ V_DISPLAY
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- line_start  out  1  strobe on the tick where x == 0
- frame_start  out  1  strobe on the tick where x == 0 && y == 0
- frame_cnt  out  FRAME_W  completed-frame count

## Operation
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL equivalent. Region order is display, front porch, sync, back porch.
- Divider: counter of width max(1, clog2(CLK_DIV)).
  - p_tick = en && (div == CLK_DIV-1) && !reset.
  - div advances only when en = 1 and wraps at CLK_DIV-1.
  - With CLK_DIV = 1, p_tick = en.
- Counters: on a clk edge with p_tick = 1:
  - x ← (x == H_TOTAL-1) ? 0 : x+1.
  - y advances only when x == H_TOTAL-1, and wraps at V_TOTAL-1.
- Sync windows:
  - hsync is active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], exactly H_SYNC ticks.
  - vsync is active for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], exactly V_SYNC lines.
- video_on, hblank, vblank, hsync and vsync are registered. They are computed from the next-state counter values, so each corresponds to the x/y held in the same cycle, with zero skew and no combinational path from counters to pins.
- line_start = p_tick && x == 0. frame_start = p_tick && x == 0 && y == 0.
- en = 0: divider, counters and all registered outputs hold; strobes are 0. Resuming continues from the frozen divider phase.
- Elaboration check: if H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits, or CLK_DIV = 0, simulation stops with a fatal message.

## Timing
- Reset values:
  - div = 0, x = 0, y = 0
  - video_on = 1, hblank = 0, vblank = 0
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL
  - p_tick = line_start = frame_start = 0
  - frame_cnt = 0
- Reset asserted mid-frame takes effect on the next clk edge. The same reset values apply, and the strobes are forced to 0 while reset is high.
- After reset is released with en = 1, the first p_tick arrives on clk cycle CLK_DIV-1, counting the first post-reset cycle as cycle 0. That tick is a frame_start.
- Line period = H_TOTAL·CLK_DIV clk cycles. Frame period = V_TOTAL·H_TOTAL·CLK_DIV clk cycles.
- A simultaneous x and y wrap occurs in a single edge, moving (H_TOTAL-1, V_TOTAL-1) to (0,0).

## Configuration
- VTG_FRAME_CNT_EN defined: frame_cnt increments, modulo 2^FRAME_W, on the p_tick edge where x == H_TOTAL-1 && y == V_TOTAL-1. It holds under en = 0 and clears on reset.
- VTG_FRAME_CNT_EN undefined: the frame_cnt port is still present, but tied to 0 and has no register.

## Test plan
- Default params, en = 1:
  - p_tick is seen every 4 clk.
  - hsync is low for exactly 96 ticks, at x = 656..751.
  - line = 3200 clk.
  - vsync is low only for y = 490..491.
  - frame_start spacing = 1,680,000 clk.
- H = 4/1/1/1, V = 3/1/1/1, CLK_DIV = 1:
  - x cycles 0..6 and y cycles 0..5.
  - video_on is high for 12 of every 42 cycles.
  - hsync is active only at x = 5.
  - frame_start recurs every 42 cycles.
- en is dropped for 10 clk at x = 100, with default params:
  - x, y and outputs hold.
  - p_tick, line_start and frame_start stay 0.
  - After resume the next tick advances x to 101, with no tick lost or duplicated.
- Reset pulsed for 1 clk at (x, y) = (700, 300):
  - Next cycle is x = 0, y = 0, hsync = 1, vsync = 1, video_on = 1.
  - The first p_tick follows 3 clk later, together with frame_start.
- H_SYNC_POL = 1, V_SYNC_POL = 1: the sync outputs are the exact bitwise inverse of the default run, cycle for cycle.
- VTG_FRAME_CNT_EN defined, FRAME_W = 2, small geometry from the second scenario: frame_cnt steps 0→1→2→3→0 at each wrap to (0,0), coincident with frame_start. With the macro undefined, frame_cnt stays 0 throughout.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-tick divider, x/y counters, registered sync/blank flags and strobes.
// Optional completed-frame counter is built when VTG_FRAME_CNT_EN is defined; otherwise frame_cnt is tied to 0.
module video_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CLK_DIV    = 4,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CW         = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               p_tick,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               video_on,
    output logic               hblank,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
    localparam logic [CW-1:0]    CW_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    CW_ONE   = CW'(1'b1);
    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]    H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0]    V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0]    HS_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0]    HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0]    VS_FIRST = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0]    VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic             H_ACT    = (H_SYNC_POL != 0);
    localparam logic             V_ACT    = (V_SYNC_POL != 0);

    generate
        if ((longint'(H_TOTAL - 1) >= (longint'(1) << CW)) ||
            (longint'(V_TOTAL - 1) >= (longint'(1) << CW)) || (CLK_DIV < 1)) begin : g_bad_cfg
            $fatal(1, "video_timing_gen: geometry does not fit CW bits or CLK_DIV is zero");
        end
    endgenerate

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic [CW-1:0]    x_r;
    logic [CW-1:0]    y_r;
    logic [CW-1:0]    x_nxt_s;
    logic [CW-1:0]    y_nxt_s;
    logic             tick_s;
    logic             video_on_r;
    logic             hblank_r;
    logic             vblank_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             video_on_nxt_s;
    logic             hblank_nxt_s;
    logic             vblank_nxt_s;
    logic             hsync_nxt_s;
    logic             vsync_nxt_s;

    assign tick_s = en && (div_r == DIV_LAST) && !reset;

    // Next divider phase and raster position; all hold while en is low
    always_comb begin
        div_nxt_s = div_r;
        x_nxt_s   = x_r;
        y_nxt_s   = y_r;
        if (en) begin
            if (div_r == DIV_LAST) begin
                div_nxt_s = DIV_ZERO;
            end else begin
                div_nxt_s = div_r + DIV_ONE;
            end
        end else begin
            div_nxt_s = div_r;
        end
        if (tick_s) begin
            if (x_r == H_LAST) begin
                x_nxt_s = CW_ZERO;
                if (y_r == V_LAST) begin
                    y_nxt_s = CW_ZERO;
                end else begin
                    y_nxt_s = y_r + CW_ONE;
                end
            end else begin
                x_nxt_s = x_r + CW_ONE;
                y_nxt_s = y_r;
            end
        end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
        end
    end

    // Flags decoded from the next position so the registered copies line up with x/y
    always_comb begin
        video_on_nxt_s = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
        hblank_nxt_s   = (x_nxt_s >= H_VIS);
        vblank_nxt_s   = (y_nxt_s >= V_VIS);
        hsync_nxt_s    = ((x_nxt_s >= HS_FIRST) && (x_nxt_s <= HS_LAST)) ? H_ACT : ~H_ACT;
        vsync_nxt_s    = ((y_nxt_s >= VS_FIRST) && (y_nxt_s <= VS_LAST)) ? V_ACT : ~V_ACT;
    end

    // Divider, counters and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r      <= DIV_ZERO;
            x_r        <= CW_ZERO;
            y_r        <= CW_ZERO;
            video_on_r <= 1'b1;
            hblank_r   <= 1'b0;
            vblank_r   <= 1'b0;
            hsync_r    <= ~H_ACT;
            vsync_r    <= ~V_ACT;
        end else begin
            div_r      <= div_nxt_s;
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            video_on_r <= video_on_nxt_s;
            hblank_r   <= hblank_nxt_s;
            vblank_r   <= vblank_nxt_s;
            hsync_r    <= hsync_nxt_s;
            vsync_r    <= vsync_nxt_s;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1'b1);

    logic [FRAME_W-1:0] frame_cnt_r;

    // Count frames on the tick that wraps the raster back to the origin
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= FRAME_ZERO;
        end else if (tick_s && (x_r == H_LAST) && (y_r == V_LAST)) begin
            frame_cnt_r <= frame_cnt_r + FRAME_ONE;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = {FRAME_W{1'b0}};
`endif

    assign p_tick      = tick_s;
    assign x           = x_r;
    assign y           = y_r;
    assign video_on    = video_on_r;
    assign hblank      = hblank_r;
    assign vblank      = vblank_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign line_start  = tick_s && (x_r == CW_ZERO);
    assign frame_start = tick_s && (x_r == CW_ZERO) && (y_r == CW_ZERO);

endmodule
